redmule_tile_instr_fetch_axi: RTL

Instruction-fetch AXI read initiator for the RedMulE tile. It converts the core's OBI instruction-fetch requests into single-beat AXI4 read transactions on the `core_instr_req_t`/`core_instr_rsp_t` port, which the tile exposes toward the instruction memory or I$. Read data is returned to the core in request order. The AXI write channels are tied off. The block bounds the number of in-flight reads and flags protocol violations by the responder.

---
 rtl/redmule_tile_pkg.sv | 65 ++++++
 rtl/redmule_tile_instr_fetch_axi.sv | 135 +++++++++++++
 2 files changed

// File: rtl/redmule_tile_pkg.sv
// Shared widths and AXI4 channel structs for the RedMulE tile instruction port.
package redmule_tile_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } axi_ax_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } core_instr_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } core_instr_rsp_t;

endpackage

// File: rtl/redmule_tile_instr_fetch_axi.sv
// OBI instruction fetch to single-beat AXI4 read bridge with bounded
// outstanding reads, in-order return and sticky responder-violation flag.
module redmule_tile_instr_fetch_axi #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = redmule_tile_pkg::ADDR_W,
    parameter int unsigned DATA_W          = redmule_tile_pkg::DATA_W
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             instr_req_i,
    input  logic [ADDR_W-1:0]                instr_addr_i,
    output logic                             instr_gnt_o,
    output logic                             instr_rvalid_o,
    output logic [DATA_W-1:0]                instr_rdata_o,
    output logic                             instr_err_o,
    output redmule_tile_pkg::core_instr_req_t axi_req_o,
    input  redmule_tile_pkg::core_instr_rsp_t axi_rsp_i,
    output logic                             busy_o,
    output logic                             proto_err_o
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_AR_PEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              proto_err_q;

    logic grant_s;
    logic ar_hs_s;
    logic r_hs_s;
    logic r_acc_s;
    logic unused_rsp_s;

    // Handshake qualifiers; r_ready is constant 1 so r_valid alone is a handshake.
    always_comb begin
        grant_s = (state_q == ST_IDLE) && instr_req_i && (cnt_q < CNT_MAX);
        ar_hs_s = (state_q == ST_AR_PEND) && axi_rsp_i.ar_ready;
        r_hs_s  = axi_rsp_i.r_valid;
        r_acc_s = r_hs_s && (cnt_q != {CNT_W{1'b0}});
    end

    // Next state of the AR stage and the outstanding counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_AR_PEND;
                    addr_d  = instr_addr_i & ADDR_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR_PEND: begin
                if (ar_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_AR_PEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        case ({grant_s, r_acc_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State, response register and sticky violation flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rvalid_q    <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
            err_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= r_acc_s;
            if (r_acc_s) begin
                rdata_q <= axi_rsp_i.r.data;
                err_q   <= axi_rsp_i.r.resp[1];
            end
            // Stray beats are dropped; both stray and non-last beats mark the responder.
            if (r_hs_s && ((cnt_q == {CNT_W{1'b0}}) || !axi_rsp_i.r.last)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // AXI request: AR driven from registers, write channels parked.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.ar_valid = (state_q == ST_AR_PEND);
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = 3'(OFF_W);
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar.cache = 4'b0010;
        axi_req_o.ar.prot  = 3'b100;
        axi_req_o.r_ready  = 1'b1;
        axi_req_o.b_ready  = 1'b1;
    end

    assign instr_gnt_o    = grant_s;
    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign busy_o         = (state_q != ST_IDLE) || (cnt_q != {CNT_W{1'b0}});
    assign proto_err_o    = proto_err_q;

    assign unused_rsp_s = ^{axi_rsp_i.aw_ready, axi_rsp_i.w_ready, axi_rsp_i.b_valid,
                            axi_rsp_i.b, axi_rsp_i.r.id, axi_rsp_i.r.resp[0],
                            axi_rsp_i.r.user};

endmodule
